// File: rtl/ti_bus_sampler_pkg.sv
// ============================================================================
// Module : ti_bus_sampler_pkg
// Brief  : Shared constants, FSM encoding and CRU decode helper for the TI bus sampler.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package ti_bus_sampler_pkg;

    localparam logic [15:0] TD_ADDR_DEF   = 16'h5FFF;
    localparam logic [15:0] TC_ADDR_DEF   = 16'h5FFD;
    localparam logic [3:0]  CRU_HI_NIBBLE = 4'h1;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_QUAL_WR  = 3'd1,
        ST_QUAL_CRU = 3'd2,
        ST_ACCEPT   = 3'd3,
        ST_RELEASE  = 3'd4
    } state_t;

    // True when the CRU address selects bit 0 of the card at base 0x1n00.
    function automatic logic is_dsr_bit(input logic [0:15] a, input logic [3:0] base);
        return (a[0:3] == CRU_HI_NIBBLE) && (a[4:7] == base) && (a[8:14] == 7'd0);
    endfunction

endpackage

`default_nettype wire

// File: rtl/ti_bus_sampler_if.sv
// ============================================================================
// Module : ti_bus_sampler_if
// Brief  : TI-99/4A bus signals and the qualified write outputs of the sampler.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface ti_bus_sampler_if;
    logic [0:15] ti_a;
    logic [0:7]  ti_data;
    logic        ti_memen;
    logic        ti_we;
    logic        ti_cruclk;
    logic        ti_reset;
    logic [3:0]  cru_base;
    logic        td_wr;
    logic        tc_wr;
    logic [0:7]  wr_data;
    logic        cru_dsr_en;

    modport master (
        output ti_a, ti_data, ti_memen, ti_we, ti_cruclk, ti_reset, cru_base,
        input  td_wr, tc_wr, wr_data, cru_dsr_en
    );

    modport slave (
        input  ti_a, ti_data, ti_memen, ti_we, ti_cruclk, ti_reset, cru_base,
        output td_wr, tc_wr, wr_data, cru_dsr_en
    );
endinterface

`default_nettype wire

// File: rtl/ti_bus_sampler_sync.sv
// ============================================================================
// Module : ti_bus_sampler_sync
// Brief  : STAGES-deep flop synchronizer with configurable reset value.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module ti_bus_sampler_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b1
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic d,
    output logic      q
);

    logic [STAGES-1:0] r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= {STAGES{RST_VAL}};
        end else begin
            r_sync <= {r_sync[STAGES-2:0], d};
        end
    end

    assign q = r_sync[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/ti_bus_sampler.sv
// ============================================================================
// Module : ti_bus_sampler
// Brief  : Synchronizes and glitch-qualifies TI memory/CRU writes into clk-domain strobes.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module ti_bus_sampler
    import ti_bus_sampler_pkg::*;
#(
    parameter int          SYNC_STAGES = 2,
    parameter int          QUAL_CYCLES = 3,
    parameter logic [15:0] TD_ADDR     = TD_ADDR_DEF,
    parameter logic [15:0] TC_ADDR     = TC_ADDR_DEF
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    ti_bus_sampler_if.slave bus
);

    localparam logic [3:0] C_QUAL = 4'(QUAL_CYCLES);

    logic [3:0]  w_async;
    logic [3:0]  w_synced;
    logic        w_we_s, w_memen_s, w_cruclk_s, w_reset_s;
    logic [0:15] r_a;
    logic [0:7]  r_data;
    state_t      r_state, w_next;
    logic [3:0]  r_cnt, w_cnt_next;
    logic        r_is_wr, w_is_wr_next;
    logic        w_fire;
    logic        r_td_wr, r_tc_wr, r_dsr_en;
    logic [0:7]  r_wr_data;

    assign w_async = {bus.ti_reset, bus.ti_cruclk, bus.ti_memen, bus.ti_we};

    for (genvar i = 0; i < 4; i++) begin : g_sync
        ti_bus_sampler_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync (
            .clk   (clk),
            .rst_n (rst_n),
            .d     (w_async[i]),
            .q     (w_synced[i])
        );
    end

    assign w_we_s     = w_synced[0];
    assign w_memen_s  = w_synced[1];
    assign w_cruclk_s = w_synced[2];
    assign w_reset_s  = w_synced[3];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_data  <= '0;
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_is_wr <= 1'b0;
        end else begin
            r_a     <= bus.ti_a;
            r_data  <= bus.ti_data;
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            r_is_wr <= w_is_wr_next;
        end
    end

    // The accept action fires on the transition into ACCEPT so the strobe lands on the ACCEPT cycle.
    always_comb begin
        w_next       = r_state;
        w_cnt_next   = r_cnt;
        w_is_wr_next = r_is_wr;
        w_fire       = 1'b0;
        if (!w_reset_s) begin
            w_next     = ST_IDLE;
            w_cnt_next = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_cnt_next = '0;
                    if (!w_we_s && !w_memen_s) begin
                        w_next       = ST_QUAL_WR;
                        w_cnt_next   = 4'd1;
                        w_is_wr_next = 1'b1;
                    end else if (!w_cruclk_s) begin
                        w_next       = ST_QUAL_CRU;
                        w_cnt_next   = 4'd1;
                        w_is_wr_next = 1'b0;
                    end
                end
                ST_QUAL_WR, ST_QUAL_CRU: begin
                    if ((r_state == ST_QUAL_WR) ? (w_we_s || w_memen_s) : w_cruclk_s) begin
                        w_next     = ST_IDLE;
                        w_cnt_next = '0;
                    end else if (r_cnt >= C_QUAL) begin
                        w_next = ST_ACCEPT;
                        w_fire = 1'b1;
                    end else if (r_cnt != 4'hF) begin
                        w_cnt_next = r_cnt + 4'd1;
                    end
                end
                ST_ACCEPT: begin
                    w_next     = ST_RELEASE;
                    w_cnt_next = '0;
                end
                ST_RELEASE: begin
                    if (r_is_wr ? (w_we_s && w_memen_s) : w_cruclk_s) begin
                        w_next = ST_IDLE;
                    end
                end
                default: begin
                    w_next     = ST_IDLE;
                    w_cnt_next = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_td_wr   <= 1'b0;
            r_tc_wr   <= 1'b0;
            r_wr_data <= '0;
            r_dsr_en  <= 1'b0;
        end else begin
            r_td_wr <= 1'b0;
            r_tc_wr <= 1'b0;
            if (!w_reset_s) begin
                r_dsr_en <= 1'b0;
            end else if (w_fire) begin
                if (r_is_wr) begin
                    r_wr_data <= r_data;
                    r_td_wr   <= (r_a == TD_ADDR);
                    r_tc_wr   <= (r_a == TC_ADDR);
                end else if (is_dsr_bit(r_a, bus.cru_base)) begin
                    r_dsr_en <= r_a[15];
                end
            end
        end
    end

    assign bus.td_wr      = r_td_wr;
    assign bus.tc_wr      = r_tc_wr;
    assign bus.wr_data    = r_wr_data;
    assign bus.cru_dsr_en = r_dsr_en;

endmodule

`default_nettype wire
